// File: rtl/pwl_func_eval.sv
// Piecewise-linear function evaluator: y = c0 +/- round(c1*frac >> FRAC_W),
// saturated to [0, 2^C0_W-1]. The coefficient table is loaded word by word
// over the cfg port. The evaluation pipeline has three registered stages under
// a single global stall.
module pwl_func_eval #(
  parameter int SEG_BITS  = 6,
  parameter int IN_W      = 16,
  parameter int C0_W      = 20,
  parameter int C1_W      = 12,
  parameter bit SLOPE_NEG = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [C0_W+C1_W-1:0] cfg_data,
  output logic                 load_done,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_W-1:0]      in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [C0_W-1:0]      out_data
);

  localparam int FRAC_W = IN_W - SEG_BITS;
  localparam int DEPTH  = 1 << SEG_BITS;
  localparam int PROD_W = C1_W + FRAC_W;
  localparam int TERM_W = C1_W + 1;
  localparam int Y_W    = C0_W + 2;
  localparam int STAGES = 3;
  localparam logic [PROD_W:0] HALF = {{PROD_W{1'b0}}, 1'b1} << (FRAC_W - 1);

  // Coefficient storage and load bookkeeping
  logic [C0_W+C1_W-1:0] table_q [DEPTH];
  logic [SEG_BITS-1:0]  wr_ptr_q, wr_ptr_d;
  logic                 load_done_q, load_done_d;

  // Pipeline state; vld_pipe_q[k] marks stage k occupied
  logic [STAGES:1]      vld_pipe_q;
  logic [C0_W-1:0]      c0_s1_q, c0_s2_q;
  logic [C1_W-1:0]      c1_s1_q;
  logic [FRAC_W-1:0]    frac_s1_q;
  logic [PROD_W-1:0]    prod_s2_q;
  logic [C0_W-1:0]      out_data_q;

  logic                 advance, cfg_fire, in_fire;
  logic [C0_W+C1_W-1:0] rd_ent;
  logic [PROD_W:0]      rnd;
  logic [TERM_W-1:0]    term;
  logic signed [Y_W-1:0] y;
  logic [C0_W-1:0]      y_sat;

  assign out_valid = vld_pipe_q[STAGES];
  assign out_data  = out_data_q;
  assign load_done = load_done_q;
  assign advance   = !out_valid || out_ready;
  // Loading is only allowed into an empty pipeline so no sample ever sees a
  // half-written table; a pending cfg word also blocks new samples so the
  // pipeline drains for it.
  assign cfg_ready = ~|vld_pipe_q;
  assign in_ready  = load_done_q && advance && !cfg_valid;
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign in_fire   = in_valid && in_ready;

  assign rd_ent    = table_q[in_data[IN_W-1:FRAC_W]];

  // Next load pointer / done flag; a write while done is a restart at entry 0
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    load_done_d = load_done_q;
    if (cfg_fire) begin
      wr_ptr_d    = wr_ptr_q + 1'b1;
      load_done_d = load_done_q ? 1'b0 : (&wr_ptr_q);
    end
  end

  // Load pointer and done flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      load_done_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      load_done_q <= load_done_d;
    end
  end

  // Table write; contents survive reset and are gated by load_done instead
  always_ff @(posedge clk) begin
    if (cfg_fire) table_q[wr_ptr_q] <= cfg_data;
  end

  // Round half-up, apply the slope sign, then saturate to the output range
  always_comb begin
    rnd   = {1'b0, prod_s2_q} + HALF;
    term  = TERM_W'(rnd >> FRAC_W);
    y     = '0;
    y_sat = '0;
    if (SLOPE_NEG) y = $signed({2'b00, c0_s2_q}) - $signed({{(Y_W-TERM_W){1'b0}}, term});
    else           y = $signed({2'b00, c0_s2_q}) + $signed({{(Y_W-TERM_W){1'b0}}, term});
    if (y[Y_W-1])                 y_sat = '0;
    else if (|y[Y_W-2:C0_W])      y_sat = '1;
    else                          y_sat = y[C0_W-1:0];
  end

  // Three-stage pipeline: S1 table read + frac, S2 multiply, S3 round/sat
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      c0_s1_q    <= '0;
      c1_s1_q    <= '0;
      frac_s1_q  <= '0;
      c0_s2_q    <= '0;
      prod_s2_q  <= '0;
      out_data_q <= '0;
    end else if (advance) begin
      vld_pipe_q <= {vld_pipe_q[STAGES-1:1], in_fire};
      c0_s1_q    <= rd_ent[C0_W+C1_W-1:C1_W];
      c1_s1_q    <= rd_ent[C1_W-1:0];
      frac_s1_q  <= in_data[FRAC_W-1:0];
      c0_s2_q    <= c0_s1_q;
      prod_s2_q  <= PROD_W'(c1_s1_q) * PROD_W'(frac_s1_q);
      if (vld_pipe_q[2]) out_data_q <= y_sat;
    end
  end

endmodule

// File: tb/tb_pwl_func_eval.sv
// Scoreboard bench for pwl_func_eval: two instances (falling and rising slope)
// share all inputs; expected results are queued at input handshake and
// checked at output handshake.
module tb_pwl_func_eval;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_valid;
  logic [31:0] cfg_data;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_ready;

  logic        cfg_ready, load_done, in_ready, out_valid;
  logic [19:0] out_data;
  logic        cfg_ready_p, load_done_p, in_ready_p, out_valid_p;
  logic [19:0] out_data_p;

  typedef struct { logic [19:0] neg; logic [19:0] pos; } exp_t;
  exp_t        sb_q[$];
  logic [31:0] mtbl [64];
  int          mptr;
  logic [31:0] tbl_img [64];
  bit          held_v;
  logic [19:0] held_d;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pwl_func_eval #(.SLOPE_NEG(1'b1)) u_neg (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data), .load_done(load_done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data));

  pwl_func_eval #(.SLOPE_NEG(1'b0)) u_pos (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready_p), .cfg_data(cfg_data), .load_done(load_done_p),
    .in_valid(in_valid), .in_ready(in_ready_p), .in_data(in_data),
    .out_valid(out_valid_p), .out_ready(out_ready), .out_data(out_data_p));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] model(input logic [31:0] w, input logic [9:0] frac, input bit neg);
    longint prod, term, y;
    prod = longint'(w[11:0]) * longint'(frac);
    term = (prod + 512) >> 10;
    y    = neg ? longint'(w[31:12]) - term : longint'(w[31:12]) + term;
    if (y < 0)        y = 0;
    if (y > 'hFFFFF)  y = 'hFFFFF;
    return 20'(y);
  endfunction

  // Scoreboard: table model, expected pushes, output pops, stall hold check
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      mptr   = 0;
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        chk("hold_valid", {31'd0, out_valid}, 32'd1);
        chk("hold_data", {12'd0, out_data}, {12'd0, held_d});
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) chk("unexpected_out", {31'd0, out_valid}, 32'd0);
        else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("out_neg", {12'd0, out_data}, {12'd0, e.neg});
          chk("valid_pos", {31'd0, out_valid_p}, 32'd1);
          chk("out_pos", {12'd0, out_data_p}, {12'd0, e.pos});
        end
      end
      held_v = out_valid && !out_ready;
      held_d = out_data;
      if (cfg_valid && cfg_ready) begin
        mtbl[mptr] = cfg_data;
        mptr = (mptr + 1) % 64;
      end
      if (in_valid && in_ready) begin
        exp_t e;
        e.neg = model(mtbl[in_data[15:10]], in_data[9:0], 1'b1);
        e.pos = model(mtbl[in_data[15:10]], in_data[9:0], 1'b0);
        sb_q.push_back(e);
      end
    end
  end

  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic cfg_word(input logic [31:0] w);
    int t = 0;
    cfg_valid = 1'b1;
    cfg_data  = w;
    @(negedge clk);
    while (!cfg_ready) begin
      t++;
      if (t > 200) begin chk("cfg_timeout", t, 0); break; end
      @(negedge clk);
    end
    sync();
    cfg_valid = 1'b0;
  endtask

  task automatic load_table(input int first);
    for (int i = first; i < 64; i++) begin
      cfg_word(tbl_img[i]);
      if (i == 62) chk("load_done_early", {31'd0, load_done}, 32'd0);
      if (i == 63) chk("load_done_set", {31'd0, load_done}, 32'd1);
    end
  endtask

  task automatic fill_img();
    for (int i = 0; i < 64; i++) tbl_img[i] = $urandom();
  endtask

  task automatic send(input logic [15:0] d, output int waits);
    in_valid = 1'b1;
    in_data  = d;
    waits    = 0;
    @(negedge clk);
    while (!in_ready) begin
      waits++;
      if (waits > 200) begin chk("send_timeout", waits, 0); break; end
      @(negedge clk);
    end
    sync();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    @(negedge clk);
    while (sb_q.size() != 0 || out_valid) begin
      t++;
      if (t > 100) begin chk("drain_timeout", sb_q.size(), 0); break; end
      @(negedge clk);
    end
    sync();
  endtask

  task automatic rst_pulse();
    rst_n = 1'b0;
    sync();
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, tot, acc, lat;
    bit took;
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) sync();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {12'd0, out_data}, 32'd0);
    chk("rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
    chk("rst_load_done", {31'd0, load_done}, 32'd0);
    chk("rst_pos_ready", {29'd0, in_ready_p, load_done_p, out_valid_p}, 32'd0);
    chk("rst_pos_cfg", {31'd0, cfg_ready_p}, 32'd1);
    sync();

    // Initial table: known entries 0..2, random 3..9, zero elsewhere
    for (int i = 0; i < 64; i++) tbl_img[i] = '0;
    tbl_img[0] = {20'h002D1, 12'h43F};
    tbl_img[1] = {20'd5, 12'hFFF};
    tbl_img[2] = {20'hFFFFF, 12'hFFF};
    for (int i = 3; i < 10; i++) tbl_img[i] = $urandom();
    load_table(0);

    // Latency of a lone sample
    send(16'h0000, w);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!out_valid && lat < 10);
    chk("latency", lat, 3);
    sync();
    wait_drain();

    // Directed points: mid frac, underflow, overflow, zero frac
    send(16'h0200, w);
    send(16'h07FF, w);
    send(16'h0BFF, w);
    send(16'h0800, w);
    // Back-to-back random stream must not see a single stall cycle
    tot = 0;
    for (int k = 0; k < 24; k++) begin
      send({6'($urandom_range(0, 9)), 10'($urandom())}, w);
      tot += w;
    end
    chk("throughput_waits", tot, 0);
    wait_drain();

    // Backpressure: exactly three accepted, then release
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = {6'($urandom_range(0, 9)), 10'($urandom())};
    acc = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      took = in_ready;
      if (took) acc++;
      sync();
      if (took) in_data = {6'($urandom_range(0, 9)), 10'($urandom())};
    end
    chk("bp_accepted", acc, 3);
    chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_accept", {31'd0, in_ready}, 32'd1);
    sync();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_drain_valid", {31'd0, out_valid}, 32'd1);
    end
    sync();
    wait_drain();

    // Restart with empty pipeline: cfg beats a simultaneous sample
    fill_img();
    cfg_valid = 1'b1; cfg_data = tbl_img[0];
    in_valid  = 1'b1; in_data  = 16'($urandom());
    @(negedge clk);
    chk("prio_in_ready", {31'd0, in_ready}, 32'd0);
    chk("prio_cfg_ready", {31'd0, cfg_ready}, 32'd1);
    sync();
    cfg_valid = 1'b0;
    chk("restart_clears", {31'd0, load_done}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("reload_in_blocked", {31'd0, in_ready}, 32'd0);
    end
    sync();
    load_table(1);
    @(negedge clk);
    chk("in_ready_after_load", {31'd0, in_ready}, 32'd1);
    sync();
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) send(16'($urandom()), w);
    wait_drain();

    // cfg arriving with samples in flight waits for the drain
    out_ready = 1'b0;
    send(16'($urandom()), w);
    send(16'($urandom()), w);
    fill_img();
    cfg_valid = 1'b1; cfg_data = tbl_img[0];
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("cfg_blocked", {31'd0, cfg_ready}, 32'd0);
    end
    sync();
    out_ready = 1'b1;
    lat = 0;
    @(negedge clk);
    while (!cfg_ready && lat < 50) begin lat++; @(negedge clk); end
    chk("cfg_after_drain_valid", {31'd0, out_valid}, 32'd0);
    chk("cfg_after_drain_sb", sb_q.size(), 0);
    sync();
    cfg_valid = 1'b0;
    chk("restart2_clears", {31'd0, load_done}, 32'd0);
    load_table(1);
    for (int k = 0; k < 8; k++) send(16'($urandom()), w);
    wait_drain();

    // Reset with two samples in flight
    out_ready = 1'b0;
    send(16'($urandom()), w);
    send(16'($urandom()), w);
    rst_pulse();
    @(negedge clk);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_load_done", {31'd0, load_done}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    sync();
    out_ready = 1'b1;

    // Reset part-way through a load, then a full load from entry 0
    fill_img();
    for (int k = 0; k < 10; k++) cfg_word(tbl_img[k]);
    rst_pulse();
    chk("midload_load_done", {31'd0, load_done}, 32'd0);
    load_table(0);
    repeat (10) sync();
    for (int k = 0; k < 8; k++) send(16'($urandom()), w);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
